// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : Request/response bundle between the EX stage and div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [4:0]       tag_in;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       tag_out;

    modport master (
        output flush, start, op, src1, src2, tag_in,
        input  busy, stall_req, done, result, tag_out
    );

    modport slave (
        input  flush, start, op, src1, src2, tag_in,
        output busy, stall_req, done, result, tag_out
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring 32-bit divider (DIV.W/MOD.W/DIV.WU/MOD.WU)
//               with pipeline stall request and one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic   cpu_clk,
    input  wire logic   cpu_rst,
    div_unit_if.slave   dif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;
    localparam logic [5:0] c_LAST = 6'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_is_mod;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_tag;

    logic             w_signed_op;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic             w_div_zero;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_ok;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_busy;

    // op[1] selects the unsigned variants; op[0] selects remainder output.
    assign w_signed_op = ~dif.op[1];
    assign w_neg1      = w_signed_op & dif.src1[WIDTH-1];
    assign w_neg2      = w_signed_op & dif.src2[WIDTH-1];
    assign w_abs1      = w_neg1 ? (~dif.src1 + 1'b1) : dif.src1;
    assign w_abs2      = w_neg2 ? (~dif.src2 + 1'b1) : dif.src2;
    assign w_div_zero  = (dif.src2 == '0);

    // The partial remainder is always below the divisor, so a 33-bit trial
    // subtraction is enough for both the signed and unsigned magnitudes.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_div};
    assign w_trial_ok = ~w_trial[WIDTH];

    assign w_quo_fix = r_qsign ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_rsign ? (~r_rem + 1'b1) : r_rem;

    assign w_busy        = (r_state == c_CALC) || (r_state == c_FIX);
    assign dif.busy      = w_busy;
    assign dif.stall_req = (dif.start & (r_state == c_IDLE) & ~dif.flush) | w_busy;
    assign dif.done      = r_done;
    assign dif.result    = r_result;
    assign dif.tag_out   = r_tag;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_is_mod <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (dif.flush) begin
            r_state <= c_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (dif.start) begin
                        r_is_mod <= dif.op[0];
                        r_tag    <= dif.tag_in;
                        if (w_div_zero) begin
                            r_result <= dif.op[0] ? dif.src1 : '1;
                            r_done   <= 1'b1;
                            r_state  <= c_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_abs1;
                            r_div   <= w_abs2;
                            r_cnt   <= '0;
                            r_qsign <= w_neg1 ^ w_neg2;
                            r_rsign <= w_neg1;
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_rem   <= w_trial_ok ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    r_quo   <= {r_quo[WIDTH-2:0], w_trial_ok};
                    r_cnt   <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_result <= r_is_mod ? w_rem_fix : w_quo_fix;
                    r_done   <= 1'b1;
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    // The instruction still occupies EX here, so start is ignored.
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_MOD  = 2'b01;
    localparam logic [1:0] c_DIVU = 2'b10;
    localparam logic [1:0] c_MODU = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32)) u_dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .dif     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic avoids the INT_MIN/-1 overflow trap.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return o[0] ? a : 32'hFFFF_FFFF;
        if (o[1]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return o[0] ? r[31:0] : q[31:0];
    endfunction

    task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input bit scramble, input bit keep,
                          output logic [31:0] res, output logic [4:0] tg,
                          output int lat, output int stalls, output bit busy_seen);
        @(negedge clk);
        dif.start = 1'b1; dif.op = o; dif.src1 = a; dif.src2 = b; dif.tag_in = t;
        lat = 0; stalls = 0; busy_seen = 1'b0;
        #1;
        while (dif.done !== 1'b1 && lat < 40) begin
            if (dif.stall_req === 1'b1) stalls++;
            if (dif.busy === 1'b1) busy_seen = 1'b1;
            @(negedge clk);
            lat++;
            if (scramble) begin
                dif.src1 = $urandom; dif.src2 = $urandom;
                dif.op = 2'($urandom); dif.tag_in = 5'($urandom);
            end
            #1;
        end
        chk("done_seen", {31'd0, dif.done}, 32'd1);
        res = dif.result;
        tg  = dif.tag_out;
        chk("stall_in_done", {31'd0, dif.stall_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("done_single", {31'd0, dif.done}, 32'd0);
        chk("result_hold", dif.result, res);
        if (!keep) dif.start = 1'b0;
    endtask

    logic [31:0] res;
    logic [4:0]  tg;
    int          lat, stalls, dcount;
    bit          bseen;

    typedef struct { logic [1:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    vec_t vecs[$];

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        dif.flush = 1'b0; dif.start = 1'b0; dif.op = 2'b00;
        dif.src1 = '0; dif.src2 = '0; dif.tag_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done",   {31'd0, dif.done}, 32'd0);
        chk("rst_busy",   {31'd0, dif.busy}, 32'd0);
        chk("rst_stall",  {31'd0, dif.stall_req}, 32'd0);
        chk("rst_result", dif.result, 32'd0);
        chk("rst_tag",    {27'd0, dif.tag_out}, 32'd0);
        rst = 1'b0;

        // Unsigned basic case with stall/latency accounting.
        do_div(c_DIVU, 32'd100, 32'd7, 5'd9, 1'b0, 1'b0, res, tg, lat, stalls, bseen);
        chk("divu_res",    res, 32'd14);
        chk("divu_tag",    {27'd0, tg}, 32'd9);
        chk("divu_lat",    32'(lat), 32'd34);
        chk("divu_stalls", 32'(stalls), 32'd34);

        vecs.push_back('{c_MODU, 32'd100,        32'd7,          32'd2});
        vecs.push_back('{c_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
        vecs.push_back('{c_MOD,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
        vecs.push_back('{c_MOD,  32'd7,          32'hFFFF_FFFE,  32'd1});
        vecs.push_back('{c_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
        vecs.push_back('{c_MOD,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{c_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});
        vecs.push_back('{c_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1});
        foreach (vecs[i]) begin
            do_div(vecs[i].o, vecs[i].a, vecs[i].b, 5'(i + 3), 1'b1, 1'b0, res, tg, lat, stalls, bseen);
            chk("dir_res", res, vecs[i].exp);
            chk("dir_tag", {27'd0, tg}, 32'(i + 3));
        end

        // Divide by zero.
        do_div(c_DIV, 32'd5, 32'd0, 5'd17, 1'b0, 1'b0, res, tg, lat, stalls, bseen);
        chk("dz_div_res",  res, 32'hFFFF_FFFF);
        chk("dz_div_lat",  32'(lat), 32'd1);
        chk("dz_div_busy", {31'd0, bseen}, 32'd0);
        do_div(c_MODU, 32'h1234, 32'd0, 5'd18, 1'b0, 1'b0, res, tg, lat, stalls, bseen);
        chk("dz_modu_res", res, 32'h1234);
        chk("dz_modu_tag", {27'd0, tg}, 32'd18);

        // Flush 10 cycles into CALC.
        @(negedge clk);
        dif.start = 1'b1; dif.op = c_DIVU; dif.src1 = 32'd1000; dif.src2 = 32'd3; dif.tag_in = 5'd4;
        repeat (11) @(negedge clk);
        dif.flush = 1'b1; dif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_busy",  {31'd0, dif.busy}, 32'd0);
        chk("flush_done",  {31'd0, dif.done}, 32'd0);
        chk("flush_stall", {31'd0, dif.stall_req}, 32'd0);
        chk("flush_result_kept", dif.result, 32'h1234);
        dif.flush = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done === 1'b1) dcount++;
        end
        chk("flush_no_done", 32'(dcount), 32'd0);
        do_div(c_DIVU, 32'd9, 32'd3, 5'd6, 1'b0, 1'b0, res, tg, lat, stalls, bseen);
        chk("post_flush_res", res, 32'd3);
        chk("post_flush_lat", 32'(lat), 32'd34);

        // start held through DONE: re-accept only in the following IDLE cycle.
        do_div(c_DIVU, 32'd100, 32'd7, 5'd11, 1'b0, 1'b1, res, tg, lat, stalls, bseen);
        chk("b2b_res", res, 32'd14);
        chk("b2b_idle_stall", {31'd0, dif.stall_req}, 32'd1);
        @(negedge clk);
        #1;
        chk("b2b_reaccept_busy", {31'd0, dif.busy}, 32'd1);
        chk("b2b_reaccept_done", {31'd0, dif.done}, 32'd0);
        dif.start = 1'b0; dif.flush = 1'b1;
        @(negedge clk);
        dif.flush = 1'b0;

        // Reset in the middle of CALC.
        @(negedge clk);
        dif.start = 1'b1; dif.op = c_DIV; dif.src1 = 32'd77; dif.src2 = 32'd5; dif.tag_in = 5'd21;
        repeat (6) @(negedge clk);
        rst = 1'b1; dif.start = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_done",   {31'd0, dif.done}, 32'd0);
        chk("mid_rst_busy",   {31'd0, dif.busy}, 32'd0);
        chk("mid_rst_stall",  {31'd0, dif.stall_req}, 32'd0);
        chk("mid_rst_result", dif.result, 32'd0);
        chk("mid_rst_tag",    {27'd0, dif.tag_out}, 32'd0);
        rst = 1'b0;

        // Random cases with operands scrambled while the division is in flight.
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            logic [4:0]  t;
            o = 2'($urandom_range(0, 3));
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                2: b = 32'($urandom_range(1, 15));
                default: begin
                    b = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
            endcase
            t = 5'($urandom);
            do_div(o, a, b, t, 1'b1, 1'b0, res, tg, lat, stalls, bseen);
            chk("rnd_res", res, model(o, a, b));
            chk("rnd_tag", {27'd0, tg}, {27'd0, t});
            chk("rnd_lat", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
